// File: rtl/sinaleira_pkg.sv
// Shared types for the timed traffic-light controller: phase codes, lamp codes
// and the Moore lamp decode used by the top level.
package sinaleira_pkg;

    typedef enum logic [2:0] {
        A_GRN  = 3'd0,
        A_YEL  = 3'd1,
        RED_AB = 3'd2,
        B_GRN  = 3'd3,
        B_YEL  = 3'd4,
        RED_BA = 3'd5,
        PED    = 3'd6
    } state_t;

    localparam logic [1:0] VERDE    = 2'b00;
    localparam logic [1:0] AMARELO  = 2'b01;
    localparam logic [1:0] VERMELHO = 2'b10;

    typedef struct packed {
        logic [1:0] la;
        logic [1:0] lb;
        logic       walk;
    } lamps_t;

    // Unknown codes show all-red so a corrupted phase never lights a green.
    function automatic lamps_t decode_lamps(input state_t s);
        lamps_t l;
        l = '{la: VERMELHO, lb: VERMELHO, walk: 1'b0};
        case (s)
            A_GRN:   l.la = VERDE;
            A_YEL:   l.la = AMARELO;
            B_GRN:   l.lb = VERDE;
            B_YEL:   l.lb = AMARELO;
            PED:     l.walk = 1'b1;
            default: l = '{la: VERMELHO, lb: VERMELHO, walk: 1'b0};
        endcase
        return l;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Tick counter for the current phase: synchronous clear on phase change,
// counts enabled ticks and sticks at all-ones instead of wrapping.
module phase_timer #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    output logic [CNT_W-1:0] tmr
);

    localparam logic [CNT_W-1:0] TMR_MAX = '1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr <= '0;
        end else if (clear) begin
            tmr <= '0;
        end else if (en && tmr != TMR_MAX) begin
            tmr <= tmr + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sinaleira_ctrl_temporizada.sv
// Two-street traffic-light controller with pedestrian phase, advanced by a slow
// tick. Lamps are decoded from the phase register alone; phase is exported for debug.
module sinaleira_ctrl_temporizada
    import sinaleira_pkg::*;
#(
    parameter int TMIN_GREEN = 8,
    parameter int TMAX_GREEN = 30,
    parameter int TYELLOW    = 3,
    parameter int TALLRED    = 1,
    parameter int TWALK      = 6,
    parameter int CNT_W      = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       TA,
    input  logic       TB,
    input  logic       ped_btn,
    output logic [1:0] LA,
    output logic [1:0] LB,
    output logic       walk,
    output logic [2:0] phase
);

    // Last tmr value of each timed phase; the move happens on the tick seen there.
    localparam logic [CNT_W-1:0] MIN_LAST  = CNT_W'(TMIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_LAST  = CNT_W'(TMAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(TYELLOW - 1);
    localparam logic [CNT_W-1:0] RED_LAST  = CNT_W'(TALLRED - 1);
    localparam logic [CNT_W-1:0] WALK_LAST = CNT_W'(TWALK - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] tmr;
    logic             ped_pend;
    logic             nxt_b;
    logic             dem_a;
    logic             dem_b;
    logic             state_chg;
    logic             ped_entry;
    lamps_t           lamps;

    assign dem_a     = TB | ped_pend;
    assign dem_b     = TA | ped_pend;
    assign state_chg = (state_d != state_q);
    assign ped_entry = (state_d == PED) && (state_q != PED);

    phase_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clear(state_chg),
        .en   (tick),
        .tmr  (tmr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= A_GRN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            A_GRN:
                if (tick && tmr >= MIN_LAST && dem_a && (!TA || tmr >= MAX_LAST))
                    state_d = A_YEL;
            A_YEL:
                if (tick && tmr == YEL_LAST)
                    state_d = RED_AB;
            RED_AB:
                if (tick && tmr == RED_LAST)
                    state_d = ped_pend ? PED : B_GRN;
            B_GRN:
                if (tick && tmr >= MIN_LAST && dem_b && (!TB || tmr >= MAX_LAST))
                    state_d = B_YEL;
            B_YEL:
                if (tick && tmr == YEL_LAST)
                    state_d = RED_BA;
            RED_BA:
                if (tick && tmr == RED_LAST)
                    state_d = ped_pend ? PED : A_GRN;
            PED:
                if (tick && tmr == WALK_LAST)
                    state_d = nxt_b ? B_GRN : A_GRN;
            default:
                state_d = A_GRN;
        endcase
    end

    // Request is remembered until the walk phase actually starts; presses during walk are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ped_pend <= 1'b0;
        end else if (ped_entry) begin
            ped_pend <= 1'b0;
        end else if (ped_btn && state_q != PED) begin
            ped_pend <= 1'b1;
        end
    end

    // Remembers which street gets green after the walk, so the rotation is not lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nxt_b <= 1'b0;
        end else if (ped_entry) begin
            nxt_b <= (state_q == RED_AB);
        end
    end

    assign lamps = decode_lamps(state_q);
    assign LA    = lamps.la;
    assign LB    = lamps.lb;
    assign walk  = lamps.walk;
    assign phase = state_q;

endmodule
